// File: rtl/audio_pkg.sv
// Shared audio types for the I2S capture path.
// Sample width, channel encoding and receiver states.
package audio_pkg;

    localparam int AUDIO_DATA_W = 16;

    typedef logic [AUDIO_DATA_W-1:0] sample_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    typedef enum logic {
        RX_SYNC,
        RX_RUN
    } rx_state_e;

endpackage

// File: rtl/i2s_pin_sync.sv
// Two-flop synchronisers for the codec pins.
// A third BCK flop provides the rising-edge strobe.
module i2s_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic bck,
    input  logic ws,
    input  logic din,
    output logic ws_s,
    output logic din_s,
    output logic bck_rise
);

    logic bck_s1;
    logic bck_s2;
    logic bck_s3;
    logic ws_s1;
    logic din_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            bck_s1 <= 1'b0;
            bck_s2 <= 1'b0;
            bck_s3 <= 1'b0;
            ws_s1  <= 1'b0;
            ws_s   <= 1'b0;
            din_s1 <= 1'b0;
            din_s  <= 1'b0;
        end else begin
            bck_s1 <= bck;
            bck_s2 <= bck_s1;
            bck_s3 <= bck_s2;
            ws_s1  <= ws;
            ws_s   <= ws_s1;
            din_s1 <= din;
            din_s  <= din_s1;
        end
    end

    assign bck_rise = bck_s2 & ~bck_s3;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: Philips-format slots in, L/R pairs out on valid/ready.
// Optional slot-length checking is enabled by I2S_RX_FRAME_CHECK_EN.
module i2s_rx
    import audio_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MAX_SLOT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ADC_BCK,
    input  logic              ADC_WS,
    input  logic              ADC_DOUT,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(MAX_SLOT + 1);
    localparam logic [DATA_W-1:0] MSB_BIT = {1'b1, {(DATA_W-1){1'b0}}};

    logic ws_s;
    logic din_s;
    logic bck_rise;

    i2s_pin_sync u_pin_sync (
        .clk      (clk),
        .rst      (rst),
        .bck      (ADC_BCK),
        .ws       (ADC_WS),
        .din      (ADC_DOUT),
        .ws_s     (ws_s),
        .din_s    (din_s),
        .bck_rise (bck_rise)
    );

    rx_state_e         state;
    logic              ws_prev;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] word;
    logic              cmp_vld;
    chan_e             cmp_chan;
    logic [DATA_W-1:0] cmp_word;
    logic [DATA_W-1:0] hold_left;
    logic              left_ok;

    // Shifting past the word width yields zero, which truncates long slots.
    always_comb begin
        word = asm_q | ({DATA_W{din_s}} & (MSB_BIT >> bit_cnt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RX_SYNC;
            ws_prev  <= 1'b0;
            bit_cnt  <= '0;
            asm_q    <= '0;
            cmp_vld  <= 1'b0;
            cmp_chan <= CH_LEFT;
            cmp_word <= '0;
        end else begin
            cmp_vld <= 1'b0;
            if (bck_rise) begin
                ws_prev <= ws_s;
                case (state)
                    RX_SYNC: begin
                        if (ws_s != ws_prev) begin
                            bit_cnt <= '0;
                            asm_q   <= '0;
                            state   <= RX_RUN;
                        end
                    end
                    RX_RUN: begin
                        if (ws_s != ws_prev) begin
                            cmp_vld  <= 1'b1;
                            cmp_chan <= chan_e'(ws_prev);
                            cmp_word <= word;
                            bit_cnt  <= '0;
                            asm_q    <= '0;
                        end else begin
                            asm_q <= word;
                            if (bit_cnt != CNT_W'(MAX_SLOT))
                                bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= RX_SYNC;
                endcase
            end
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic             cmp_len_bad;
    logic [CNT_W-1:0] slot_len;

    assign slot_len = bit_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_len_bad <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (bck_rise && state == RX_RUN && ws_s != ws_prev)
                cmp_len_bad <= (slot_len != CNT_W'(DATA_W));
            frame_err <= cmp_vld & cmp_len_bad;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            hold_left <= '0;
            left_ok   <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (cmp_vld) begin
                if (cmp_chan == CH_LEFT) begin
                    hold_left <= cmp_word;
                    left_ok   <= 1'b1;
                end else if (left_ok) begin
                    out_left  <= hold_left;
                    out_right <= cmp_word;
                    out_valid <= 1'b1;
                    left_ok   <= 1'b0;
                    overflow  <= out_valid & ~out_ready;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: bit-level I2S source, pair scoreboard, corner sequences.
// Frame-length expectations follow I2S_RX_FRAME_CHECK_EN.
module tb_i2s_rx;

    localparam int DW = 16;
    localparam int H  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ADC_BCK = 1'b0;
    logic          ADC_WS = 1'b0;
    logic          ADC_DOUT = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_left;
    logic [DW-1:0] out_right;
    logic          out_valid;
    logic          overflow;
    logic          frame_err;

    i2s_rx #(.DATA_W(DW), .MAX_SLOT(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ADC_BCK   (ADC_BCK),
        .ADC_WS    (ADC_WS),
        .ADC_DOUT  (ADC_DOUT),
        .out_left  (out_left),
        .out_right (out_right),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    typedef struct {
        logic [31:0]   l_in;
        logic [31:0]   r_in;
        int            len;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_r;
        bit            bad_len;
    } vec_t;

    pair_t sb[$];
    int    checks = 0;
    int    failures = 0;
    int    ovf_cnt = 0;
    int    ferr_cnt = 0;
    logic  pend_valid = 1'b0;
    logic  pend_d = 1'b0;
    logic  last_ws = 1'b0;
    bit    lat_arm = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        pair_t e;
        if (overflow) ovf_cnt++;
        if (frame_err) ferr_cnt++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got %h/%h expected no pair",
                         out_left, out_right);
            end else begin
                e = sb.pop_front();
                chk("sb_left", 32'(out_left), 32'(e.l));
                chk("sb_right", 32'(out_right), 32'(e.r));
            end
        end
    end

    // One BCK period: WS/DOUT change with the falling edge.
    task automatic emit(logic ws, logic d);
        bit do_lat;
        do_lat   = lat_arm && !ws && last_ws;
        ADC_BCK  = 1'b0;
        ADC_WS   = ws;
        ADC_DOUT = d;
        last_ws  = ws;
        repeat (H) @(negedge clk);
        ADC_BCK = 1'b1;
        if (do_lat) begin
            lat_arm = 1'b0;
            repeat (3) @(posedge clk);
            #1 chk("lat_edge2_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1 chk("lat_edge3_valid", 32'(out_valid), 32'd1);
            chk("lat_left", 32'(out_left), 32'h1234);
            chk("lat_right", 32'(out_right), 32'hABCD);
            repeat (H - 3) @(negedge clk);
        end else begin
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    // A bit is emitted once the channel of the following bit is known.
    task automatic slot(logic ch, logic [31:0] w, int len, int rst_at = -1);
        for (int i = 0; i < len; i++) begin
            logic b;
            b = w[len-1-i];
            if (pend_valid) emit(ch, pend_d);
            pend_d     = b;
            pend_valid = 1'b1;
            if (i == rst_at) pulse_rst();
        end
    endtask

    task automatic flush(logic next_ch);
        if (pend_valid) emit(next_ch, pend_d);
        pend_valid = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   c0;
        int   exp_f;

        vecs[0] = '{32'h8000, 32'h7FFF, 16, 16'h8000, 16'h7FFF, 1'b0};
        vecs[1] = '{32'h0000, 32'hFFFF, 16, 16'h0000, 16'hFFFF, 1'b0};
        vecs[2] = '{32'hAAAA, 32'h5555, 16, 16'hAAAA, 16'h5555, 1'b0};
        vecs[3] = '{32'h2AF37, 32'h4D5D, 18, 16'hABCD, 16'h1357, 1'b1};
        vecs[4] = '{32'hABC, 32'h5A5, 12, 16'hABC0, 16'h5A50, 1'b1};
        vecs[5] = '{32'hC3A5, 32'h0F1E, 16, 16'hC3A5, 16'h0F1E, 1'b0};

        repeat (4) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_left", 32'(out_left), 32'd0);
        chk("rst_right", 32'(out_right), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;

        slot(1'b0, 32'h0, 16);
        slot(1'b1, 32'h0, 16);
        sb.push_back('{16'h1234, 16'hABCD});
        slot(1'b0, 32'h1234, 16);
        lat_arm = 1'b1;
        slot(1'b1, 32'hABCD, 16);
        flush(1'b0);
        chk("lat_seen", 32'(lat_arm), 32'd0);

        foreach (vecs[k]) begin
            c0 = ferr_cnt;
            sb.push_back('{vecs[k].exp_l, vecs[k].exp_r});
            slot(1'b0, vecs[k].l_in, vecs[k].len);
            slot(1'b1, vecs[k].r_in, vecs[k].len);
            flush(1'b0);
`ifdef I2S_RX_FRAME_CHECK_EN
            exp_f = vecs[k].bad_len ? 2 : 0;
`else
            exp_f = 0;
`endif
            chk($sformatf("ferr_vec%0d", k), 32'(ferr_cnt - c0), 32'(exp_f));
        end
        chk("no_overflow", 32'(ovf_cnt), 32'd0);

        @(posedge clk) #1 out_ready = 1'b0;
        c0 = ovf_cnt;
        sb.push_back('{16'h3333, 16'h4444});
        slot(1'b0, 32'h1111, 16);
        slot(1'b1, 32'h2222, 16);
        slot(1'b0, 32'h3333, 16);
        slot(1'b1, 32'h4444, 16);
        flush(1'b0);
        chk("ovf_pulses", 32'(ovf_cnt - c0), 32'd1);
        chk("ovf_valid", 32'(out_valid), 32'd1);
        chk("ovf_left", 32'(out_left), 32'h3333);
        chk("ovf_right", 32'(out_right), 32'h4444);
        @(posedge clk) #1 out_ready = 1'b1;
        @(posedge clk) #1 chk("ovf_drop", 32'(out_valid), 32'd0);

        sb.push_back('{16'h1357, 16'h2468});
        slot(1'b0, 32'h0F0F, 16);
        slot(1'b1, 32'hF0F0, 16, 7);
        slot(1'b0, 32'h1357, 16);
        slot(1'b1, 32'h2468, 16);
        flush(1'b0);

        @(posedge clk) #1 out_ready = 1'b0;
        slot(1'b0, 32'h5555, 16);
        slot(1'b1, 32'h6666, 16);
        flush(1'b0);
        chk("held_valid", 32'(out_valid), 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        chk("rst2_valid", 32'(out_valid), 32'd0);
        chk("rst2_left", 32'(out_left), 32'd0);
        chk("rst2_right", 32'(out_right), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1 out_ready = 1'b1;
        sb.push_back('{16'h9ABC, 16'hDEF0});
        slot(1'b0, 32'h7777, 16);
        slot(1'b1, 32'h8888, 16);
        slot(1'b0, 32'h9ABC, 16);
        slot(1'b1, 32'hDEF0, 16);
        flush(1'b0);

        repeat (10) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("final_overflow", 32'(ovf_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
